// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-reconfigurable video timing generator with lead-adjustable pixel request.
//  Optional feature macro: VTG_TEST_PATTERN_EN (adds pattern_en and RGB565 colour bars).
//  Ports:
//   pixel_clk, sys_rst            clock, synchronous active-high reset
//   cfg_valid / cfg_ready         handshake into the single-entry timing shadow
//   cfg_h_* / cfg_v_*             offered horizontal / vertical timing
//   cfg_err                       1-cycle pulse when a shadowed timing is rejected at frame end
//   pixel_data                    pixel returned REQ_LEAD cycles after its data_req
//   data_req, pixel_xpos/ypos     pixel request and its coordinates (0 when idle)
//   video_hs/vs/de, video_data    registered timing and gated pixel stream
//   frame_start                   1-cycle pulse for h=0, v=0
//   pattern_en                    (VTG_TEST_PATTERN_EN only) colour-bar select, sampled at frame_start
module video_timing_gen #(
   parameter int PIX_W        = 16,
   parameter int POS_W        = 12,
   parameter int H_ACTIVE     = 1920,
   parameter int H_SYNC_START = 2008,
   parameter int H_SYNC_END   = 2052,
   parameter int H_TOTAL      = 2200,
   parameter int V_ACTIVE     = 1080,
   parameter int V_SYNC_START = 1084,
   parameter int V_SYNC_END   = 1089,
   parameter int V_TOTAL      = 1125,
   parameter bit HS_POL       = 1'b1,
   parameter bit VS_POL       = 1'b1,
`ifdef VTG_TEST_PATTERN_EN
   parameter int BAR_SHIFT    = 8,
`endif
   parameter int REQ_LEAD     = 1
) (
   input  logic             pixel_clk,
   input  logic             sys_rst,
`ifdef VTG_TEST_PATTERN_EN
   input  logic             pattern_en,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [POS_W-1:0] cfg_h_active,
   input  logic [POS_W-1:0] cfg_h_sync_start,
   input  logic [POS_W-1:0] cfg_h_sync_end,
   input  logic [POS_W-1:0] cfg_h_total,
   input  logic [POS_W-1:0] cfg_v_active,
   input  logic [POS_W-1:0] cfg_v_sync_start,
   input  logic [POS_W-1:0] cfg_v_sync_end,
   input  logic [POS_W-1:0] cfg_v_total,
   output logic             cfg_err,
   input  logic [PIX_W-1:0] pixel_data,
   output logic             data_req,
   output logic [POS_W-1:0] pixel_xpos,
   output logic [POS_W-1:0] pixel_ypos,
   output logic             video_hs,
   output logic             video_vs,
   output logic             video_de,
   output logic [PIX_W-1:0] video_data,
   output logic             frame_start
);
   typedef struct packed {
      logic [POS_W-1:0] ha, hss, hse, ht, va, vss, vse, vt;
   } timing_t;
   localparam timing_t DEF = {POS_W'(H_ACTIVE), POS_W'(H_SYNC_START), POS_W'(H_SYNC_END), POS_W'(H_TOTAL),
                              POS_W'(V_ACTIVE), POS_W'(V_SYNC_START), POS_W'(V_SYNC_END), POS_W'(V_TOTAL)};
   localparam logic [POS_W-1:0] LEAD = POS_W'(REQ_LEAD);
   localparam logic [POS_W-1:0] ONE = POS_W'(1);
   timing_t tm_q, sh_q, cfg_w;
   logic sh_full_q, elig_q, req_q, hs_q, vs_q, fs_q, err_q;
   logic [POS_W-1:0] h_q, v_q, x_q, y_q, h_d, v_d, hl_w, vl_w, hact_w;
   logic [POS_W:0] ha_w;
   logic [REQ_LEAD-1:0] de_sr_q;
   logic h_last, v_last, frame_end, win, hwrap, elig_w, legal_w, commit_w, req_w;
   assign cfg_w = {cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
                   cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total};
   assign h_last    = h_q == tm_q.ht - ONE;
   assign v_last    = v_q == tm_q.vt - ONE;
   assign frame_end = h_last && v_last;
   assign h_d = h_last ? '0 : h_q + ONE;
   assign v_d = !h_last ? v_q : v_last ? '0 : v_q + ONE;
   // Lookahead position REQ_LEAD pixels ahead of the counters; legality guarantees it crosses at most one line.
   assign ha_w  = {1'b0, h_q} + {1'b0, LEAD};
   assign hwrap = ha_w >= {1'b0, tm_q.ht};
   assign hl_w  = hwrap ? POS_W'(ha_w - {1'b0, tm_q.ht}) : h_q + LEAD;
   assign vl_w  = !hwrap ? v_q : v_last ? '0 : v_q + ONE;
   // The lookahead enters the next frame at win; the shadow is only committed at frame end if it was
   // already full then, so requests issued for the next frame and its actual timing always agree.
   assign win    = v_last && h_q == tm_q.ht - LEAD;
   assign elig_w = win ? sh_full_q : elig_q;
   assign legal_w = sh_q.ha != '0 && sh_q.ha < sh_q.hss && sh_q.hss < sh_q.hse && sh_q.hse <= sh_q.ht &&
                    sh_q.va != '0 && sh_q.va < sh_q.vss && sh_q.vss < sh_q.vse && sh_q.vse <= sh_q.vt &&
                    sh_q.ht - sh_q.ha >= LEAD;
   assign commit_w = elig_w && legal_w;
   assign hact_w   = hwrap && v_last && commit_w ? sh_q.ha : tm_q.ha;
   assign req_w    = hl_w < hact_w && vl_w < tm_q.va;
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         h_q       <= '0;
         v_q       <= '0;
         tm_q      <= DEF;
         sh_q      <= DEF;
         sh_full_q <= 1'b0;
         elig_q    <= 1'b0;
         req_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         de_sr_q   <= '0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
         fs_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         req_q   <= req_w;
         x_q     <= req_w ? hl_w : '0;
         y_q     <= req_w ? vl_w : '0;
         // de is the request delayed by REQ_LEAD, so req and de counts can never diverge (even after reset).
         de_sr_q <= (de_sr_q << 1) | REQ_LEAD'(req_q);
         hs_q    <= (h_q >= tm_q.hss && h_q < tm_q.hse) ^ ~HS_POL;
         vs_q    <= (v_q >= tm_q.vss && v_q < tm_q.vse) ^ ~VS_POL;
         fs_q    <= h_q == '0 && v_q == '0;
         err_q   <= frame_end && elig_w && !legal_w;
         elig_q  <= frame_end ? 1'b0 : elig_w;
         if (frame_end && elig_w) begin
            sh_full_q <= 1'b0;
            if (legal_w) tm_q <= sh_q;
         end else if (cfg_valid && !sh_full_q) begin
            sh_q      <= cfg_w;
            sh_full_q <= 1'b1;
         end
      end
   end
   assign cfg_ready   = !sh_full_q;
   assign cfg_err     = err_q;
   assign data_req    = req_q;
   assign pixel_xpos  = x_q;
   assign pixel_ypos  = y_q;
   assign video_hs    = hs_q;
   assign video_vs    = vs_q;
   assign video_de    = de_sr_q[REQ_LEAD-1];
   assign frame_start = fs_q;
`ifdef VTG_TEST_PATTERN_EN
   localparam logic [127:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F, 16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
   logic [POS_W-1:0] dx_q;
   logic pat_q, pat_w;
   logic [2:0] bar_idx;
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         dx_q  <= '0;
         pat_q <= 1'b0;
      end else begin
         dx_q  <= h_q;
         pat_q <= pat_w;
      end
   end
   // pattern_en takes effect on the frame_start cycle itself so the first pixel of the frame is covered.
   assign pat_w      = fs_q ? pattern_en : pat_q;
   assign bar_idx    = 3'(dx_q >> BAR_SHIFT);
   assign video_data = !video_de ? '0 : pat_w ? PIX_W'(BARS[bar_idx*16 +: 16]) : pixel_data;
`else
   assign video_data = video_de ? pixel_data : '0;
`endif
endmodule
